// File: rtl/vga_vram_arbiter_if.sv
// Bus bundle between the VRAM arbiter and its neighbours: V timing, pixel
// consumer, CPU bus and the single-port VRAM. Suffixes are from the arbiter's view.
interface vga_vram_arbiter_if #(
    parameter int unsigned ADDR_W = 19,
    parameter int unsigned DATA_W = 8
);
    logic              frame_start_i;
    logic              pix_pop_i;
    logic [DATA_W-1:0] pix_data_o;
    logic              underrun_o;
    logic              cpu_req_i;
    logic              cpu_we_i;
    logic [ADDR_W-1:0] cpu_addr_i;
    logic [DATA_W-1:0] cpu_wdata_i;
    logic              cpu_ack_o;
    logic [DATA_W-1:0] cpu_rdata_o;
    logic              mem_en_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [DATA_W-1:0] mem_rdata_i;

    // Arbiter side
    modport slave (
        input  frame_start_i, pix_pop_i,
        input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
        input  mem_rdata_i,
        output pix_data_o, underrun_o,
        output cpu_ack_o, cpu_rdata_o,
        output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
    );

    // Environment side (timing, consumer, CPU, VRAM)
    modport master (
        output frame_start_i, pix_pop_i,
        output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
        output mem_rdata_i,
        input  pix_data_o, underrun_o,
        input  cpu_ack_o, cpu_rdata_o,
        input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
    );
endinterface

// File: rtl/vga_vram_arbiter.sv
// VGA / CPU arbiter for a single-port synchronous VRAM. Prefetches pixels in
// raster order into a small FIFO and hands the remaining slots to the CPU.
// Optional feature macro: VGA_ARB_CPU_READ_EN -- when defined, CPU reads go to
// VRAM; when undefined, CPU reads are acked without a VRAM access and read 0.
module vga_vram_arbiter #(
    parameter int unsigned ADDR_W     = 19,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned NPIX       = 307200,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned LOW_WATER  = 3
) (
    input  logic              clk,
    input  logic              reset,
    vga_vram_arbiter_if.slave bus
);

    localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned FETCH_W = $clog2(NPIX + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);

    // State = kind of VRAM access driven on mem_* this cycle
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_VID    = 2'd1,
        ST_CPU_WR = 2'd2,
        ST_CPU_RD = 2'd3
    } state_e;

    state_e              state_q, state_d;

    logic [DATA_W-1:0]   fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]    count_q;
    logic [ADDR_W-1:0]   fetch_addr_q, fetch_addr_d, fetch_base;
    logic [FETCH_W-1:0]  fetched_q, fetched_d, fetched_base;
    logic                s2_vid_q, s2_live_q;

    logic [DATA_W-1:0]   pix_data_q;
    logic                underrun_q;
    logic                cpu_ack_q, cpu_ack_d;
    logic                mem_en_q, mem_en_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

    logic                flush, push, pop_req, pop_ok;
    logic [CNT_W-1:0]    fifo_base, inflight, occ;
    logic                vid_ok, cpu_slot, cpu_done;

    // Post-flush view of the fetch state used by the grant decision
    assign flush        = bus.frame_start_i;
    assign fetch_base   = flush ? '0 : fetch_addr_q;
    assign fetched_base = flush ? '0 : fetched_q;
    assign fifo_base    = flush ? '0 : count_q;
    assign inflight     = CNT_W'(state_q == ST_VID) + CNT_W'(s2_vid_q);
    assign occ          = fifo_base + inflight;
    assign vid_ok       = fetched_base < FETCH_W'(NPIX);

    // Returns of reads issued before a frame_start are dropped; flush beats pop
    assign push    = s2_vid_q && s2_live_q && !flush;
    assign pop_req = bus.pix_pop_i && !flush;
    assign pop_ok  = pop_req && (count_q != '0);

`ifdef VGA_ARB_CPU_READ_EN
    logic              s2_cpu_q;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic              cpu_busy;

    assign cpu_busy = (state_q == ST_CPU_RD) || s2_cpu_q;
    assign cpu_slot = bus.cpu_req_i && !cpu_busy && !cpu_ack_q;
    assign cpu_done = s2_cpu_q;

    // CPU read return pipeline: data lands two edges after the grant
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s2_cpu_q    <= 1'b0;
            cpu_rdata_q <= '0;
        end else begin
            s2_cpu_q <= (state_q == ST_CPU_RD);
            if (s2_cpu_q) begin
                cpu_rdata_q <= bus.mem_rdata_i;
            end
        end
    end

    assign bus.cpu_rdata_o = cpu_rdata_q;
`else
    // Reads bypass VRAM entirely: acked one cycle after being seen
    assign cpu_slot = bus.cpu_req_i && bus.cpu_we_i && !cpu_ack_q;
    assign cpu_done = bus.cpu_req_i && !bus.cpu_we_i && !cpu_ack_q;
    assign bus.cpu_rdata_o = '0;
`endif

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Slot arbitration: starving video first, then CPU, then video top-up
    always_comb begin
        state_d = ST_IDLE;
        if (vid_ok && (occ < CNT_W'(LOW_WATER))) begin
            state_d = ST_VID;
        end else if (cpu_slot) begin
            state_d = bus.cpu_we_i ? ST_CPU_WR : ST_CPU_RD;
        end else if (vid_ok && (occ < CNT_W'(FIFO_DEPTH))) begin
            state_d = ST_VID;
        end
    end

    // Next values of the VRAM strobes, CPU ack and fetch counters
    always_comb begin
        mem_en_d     = 1'b0;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        cpu_ack_d    = cpu_done;
        fetch_addr_d = fetch_base;
        fetched_d    = fetched_base;
        case (state_d)
            ST_VID: begin
                mem_en_d   = 1'b1;
                mem_addr_d = fetch_base;
                fetched_d  = fetched_base + FETCH_W'(1);
                if (fetch_base != LAST_ADDR) begin
                    fetch_addr_d = fetch_base + ADDR_W'(1);
                end
            end
            ST_CPU_WR: begin
                mem_en_d    = 1'b1;
                mem_we_d    = 1'b1;
                mem_addr_d  = bus.cpu_addr_i;
                mem_wdata_d = bus.cpu_wdata_i;
                cpu_ack_d   = 1'b1;
            end
            ST_CPU_RD: begin
                mem_en_d   = 1'b1;
                mem_addr_d = bus.cpu_addr_i;
            end
            default: ;
        endcase
    end

    // Datapath registers: VRAM port, fetch counters, read tracking, FIFO control
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            cpu_ack_q    <= 1'b0;
            fetch_addr_q <= '0;
            fetched_q    <= '0;
            s2_vid_q     <= 1'b0;
            s2_live_q    <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            pix_data_q   <= '0;
            underrun_q   <= 1'b0;
        end else begin
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            cpu_ack_q    <= cpu_ack_d;
            fetch_addr_q <= fetch_addr_d;
            fetched_q    <= fetched_d;
            s2_vid_q     <= (state_q == ST_VID);
            s2_live_q    <= (state_q == ST_VID) && !flush;
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                end
                if (pop_ok) begin
                    rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                end
                count_q <= count_q + CNT_W'(push) - CNT_W'(pop_ok);
            end
            if (pop_req) begin
                if (pop_ok) begin
                    pix_data_q <= fifo_mem[rd_ptr_q];
                end else begin
                    pix_data_q <= '0;
                    underrun_q <= 1'b1;
                end
            end
        end
    end

    // FIFO storage (no reset needed; guarded by count/pointers)
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= bus.mem_rdata_i;
        end
    end

    assign bus.pix_data_o  = pix_data_q;
    assign bus.underrun_o  = underrun_q;
    assign bus.cpu_ack_o   = cpu_ack_q;
    assign bus.mem_en_o    = mem_en_q;
    assign bus.mem_we_o    = mem_we_q;
    assign bus.mem_addr_o  = mem_addr_q;
    assign bus.mem_wdata_o = mem_wdata_q;

endmodule
